// File: rtl/alarm_controller.sv
// -----------------------------------------------------------------------------
// alarm_controller
//
// Purpose:
//   Holds a user-editable alarm time (hours/minutes), compares it against the
//   running time-of-day supplied by the upstream time counter, and sequences
//   the alarm through ringing, snooze and auto-stop. Everything runs on the
//   shared 1 Hz clock, so one cycle is one second.
//
//   The inc_hr/inc_min buttons are shared with the time counter. alarm_set
//   routes them here, but time_set wins: while the clock itself is being set,
//   the buttons are ignored by this block.
//
// Ports:
//   clk_1hz     in   1  1 Hz clock, the only clock
//   rst         in   1  synchronous active-high reset
//   cur_h       in   6  current hour   (0..23)
//   cur_m       in   6  current minute (0..59)
//   cur_s       in   6  current second (0..59)
//   time_set    in   1  time counter is in edit mode
//   alarm_set   in   1  alarm-time edit mode
//   inc_hr      in   1  hour increment button (level, sampled every cycle)
//   inc_min     in   1  minute increment button (level, sampled every cycle)
//   alarm_en    in   1  alarm armed
//   snooze      in   1  snooze request
//   stop        in   1  dismiss request
//   alm_h       out  6  stored alarm hour
//   alm_m       out  6  stored alarm minute
//   ringing     out  1  buzzer drive
//   snoozing    out  1  high while snoozing
//   snooze_cnt  out  2  snoozes used in the current alarm event
//   alarm_edit  out  1  registered alarm-edit qualifier
//
// FSM states:
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for the alarm time to match (or disarmed / editing)
//   RINGING | buzzer on, down-counter times the auto-stop
//   SNOOZE  | buzzer silenced, down-counter times the snooze interval
// -----------------------------------------------------------------------------
module alarm_controller #(
  parameter int ALARM_H_INIT = 6,
  parameter int ALARM_M_INIT = 0,
  parameter int RING_SECS    = 60,
  parameter int SNOOZE_SECS  = 300,
  parameter int MAX_SNOOZE   = 3
) (
  input  logic       clk_1hz,
  input  logic       rst,
  input  logic [5:0] cur_h,
  input  logic [5:0] cur_m,
  input  logic [5:0] cur_s,
  input  logic       time_set,
  input  logic       alarm_set,
  input  logic       inc_hr,
  input  logic       inc_min,
  input  logic       alarm_en,
  input  logic       snooze,
  input  logic       stop,
  output logic [5:0] alm_h,
  output logic [5:0] alm_m,
  output logic       ringing,
  output logic       snoozing,
  output logic [1:0] snooze_cnt,
  output logic       alarm_edit
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } state_t;

  // Counters load N-1 so that the terminal-count cycle is the Nth cycle.
  localparam logic [9:0] RING_LOAD   = 10'(RING_SECS - 1);
  localparam logic [9:0] SNOOZE_LOAD = 10'(SNOOZE_SECS - 1);
  localparam logic [1:0] SNOOZE_MAX  = 2'(MAX_SNOOZE);
  localparam logic [5:0] H_INIT      = 6'(ALARM_H_INIT);
  localparam logic [5:0] M_INIT      = 6'(ALARM_M_INIT);
  localparam logic [5:0] H_TOP       = 6'd23;
  localparam logic [5:0] M_TOP       = 6'd59;

  state_t     state;
  logic [9:0] cnt;
  logic       edit_ok;
  logic       trig;
  logic       cnt_tc;
  logic       snooze_ok;

  function automatic logic [5:0] wrap_inc(input logic [5:0] v,
                                          input logic [5:0] top);
    return (v == top) ? 6'd0 : v + 6'd1;
  endfunction

  // time_set has priority over alarm_set for the shared buttons.
  assign edit_ok = alarm_set & ~time_set;

  // A match is only possible at second 0, which is what keeps a dismissed
  // alarm from re-firing later in the same minute.
  assign trig = alarm_en & ~time_set & ~alarm_set &
                (cur_h == alm_h) & (cur_m == alm_m) & (cur_s == 6'd0);

  assign cnt_tc    = (cnt == 10'd0);
  assign snooze_ok = snooze & (snooze_cnt < SNOOZE_MAX);

  // ---------------------------------------------------------------------------
  // Alarm time register. Hour and minute wrap independently; there is no
  // carry from minutes into hours, matching how the buttons behave on the
  // time counter.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_1hz) begin
    if (rst) begin
      alm_h      <= H_INIT;
      alm_m      <= M_INIT;
      alarm_edit <= 1'b0;
    end else begin
      alarm_edit <= edit_ok;
      if (edit_ok) begin
        if (inc_hr) begin
          alm_h <= wrap_inc(alm_h, H_TOP);
        end
        if (inc_min) begin
          alm_m <= wrap_inc(alm_m, M_TOP);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Alarm sequencer. ringing/snoozing are registered alongside the state so
  // they change on exactly the same edge as the state they mirror.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_1hz) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 10'd0;
      snooze_cnt <= 2'd0;
      ringing    <= 1'b0;
      snoozing   <= 1'b0;
    end else if (!alarm_en || edit_ok) begin
      // Disarming or entering alarm edit abandons any event in progress.
      // snooze_cnt is left alone; it only clears on the next trigger.
      state    <= IDLE;
      cnt      <= 10'd0;
      ringing  <= 1'b0;
      snoozing <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (trig) begin
            state      <= RINGING;
            cnt        <= RING_LOAD;
            snooze_cnt <= 2'd0;
            ringing    <= 1'b1;
            snoozing   <= 1'b0;
          end
        end

        RINGING: begin
          if (stop) begin
            // stop outranks a simultaneous snooze.
            state    <= IDLE;
            cnt      <= 10'd0;
            ringing  <= 1'b0;
            snoozing <= 1'b0;
          end else if (snooze_ok) begin
            state      <= SNOOZE;
            cnt        <= SNOOZE_LOAD;
            snooze_cnt <= snooze_cnt + 2'd1;
            ringing    <= 1'b0;
            snoozing   <= 1'b1;
          end else if (cnt_tc) begin
            // Auto-stop; an exhausted snooze request also lands here
            // once the ring time runs out.
            state    <= IDLE;
            cnt      <= 10'd0;
            ringing  <= 1'b0;
            snoozing <= 1'b0;
          end else begin
            cnt <= cnt - 10'd1;
          end
        end

        SNOOZE: begin
          if (stop) begin
            state    <= IDLE;
            cnt      <= 10'd0;
            ringing  <= 1'b0;
            snoozing <= 1'b0;
          end else if (cnt_tc) begin
            state    <= RINGING;
            cnt      <= RING_LOAD;
            ringing  <= 1'b1;
            snoozing <= 1'b0;
          end else begin
            cnt <= cnt - 10'd1;
          end
        end

        default: begin
          state    <= IDLE;
          cnt      <= 10'd0;
          ringing  <= 1'b0;
          snoozing <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_controller.sv
module tb_alarm_controller;

  logic       clk_1hz = 1'b0;
  logic       rst;
  logic [5:0] cur_h, cur_m, cur_s;
  logic       time_set, alarm_set, inc_hr, inc_min, alarm_en, snooze, stop;
  logic [5:0] alm_h, alm_m;
  logic       ringing, snoozing;
  logic [1:0] snooze_cnt;
  logic       alarm_edit;

  alarm_controller dut (
    .clk_1hz   (clk_1hz),
    .rst       (rst),
    .cur_h     (cur_h),
    .cur_m     (cur_m),
    .cur_s     (cur_s),
    .time_set  (time_set),
    .alarm_set (alarm_set),
    .inc_hr    (inc_hr),
    .inc_min   (inc_min),
    .alarm_en  (alarm_en),
    .snooze    (snooze),
    .stop      (stop),
    .alm_h     (alm_h),
    .alm_m     (alm_m),
    .ringing   (ringing),
    .snoozing  (snoozing),
    .snooze_cnt(snooze_cnt),
    .alarm_edit(alarm_edit)
  );

  always #5 clk_1hz = ~clk_1hz;

  typedef struct {
    logic [5:0] ah;
    logic [5:0] am;
    logic       ring;
    logic       snz;
    logic [1:0] cnt;
    logic       edit;
  } exp_t;

  typedef struct {
    logic [5:0] h, m, s;
    logic       ts, as, ih, im, en, sn, sp;
    exp_t       e;
  } vec_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // bench-side model of the stored alarm time and the running clock
  logic [5:0] m_ah, m_am;
  int         t_h, t_m, t_s;

  function automatic exp_t mkexp(int ah, int am, int r, int s, int c, int e);
    exp_t x;
    x.ah = 6'(ah); x.am = 6'(am); x.ring = 1'(r); x.snz = 1'(s);
    x.cnt = 2'(c); x.edit = 1'(e);
    return x;
  endfunction

  function automatic vec_t mk(int h, int m, int s, int ts, int as, int ih,
                              int im, int en, int sn, int sp, exp_t e);
    vec_t v;
    v.h = 6'(h); v.m = 6'(m); v.s = 6'(s);
    v.ts = 1'(ts); v.as = 1'(as); v.ih = 1'(ih); v.im = 1'(im);
    v.en = 1'(en); v.sn = 1'(sn); v.sp = 1'(sp);
    v.e = e;
    return v;
  endfunction

  task automatic check_out(input string tag);
    exp_t        e;
    logic [16:0] got, want;
    n_total++;
    if (q.size() == 0) begin
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e    = q.pop_front();
    got  = {alm_h, alm_m, ringing, snoozing, snooze_cnt, alarm_edit};
    want = {e.ah, e.am, e.ring, e.snz, e.cnt, e.edit};
    if (got === want) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got alm=%0d:%0d ring=%b snz=%b cnt=%0d edit=%b, expected alm=%0d:%0d ring=%b snz=%b cnt=%0d edit=%b",
               tag, alm_h, alm_m, ringing, snoozing, snooze_cnt, alarm_edit,
               e.ah, e.am, e.ring, e.snz, e.cnt, e.edit);
    end
  endtask

  // Inputs are already driven; push the expectation, cross one edge, compare.
  task automatic tick(input string tag, input int ah, input int am, input int r,
                      input int s, input int c, input int e);
    q.push_back(mkexp(ah, am, r, s, c, e));
    @(posedge clk_1hz);
    #1;
    check_out(tag);
  endtask

  task automatic adv_time();
    t_s++;
    if (t_s == 60) begin
      t_s = 0;
      t_m++;
      if (t_m == 60) begin
        t_m = 0;
        t_h = (t_h + 1) % 24;
      end
    end
  endtask

  task automatic set_time(input int h, input int m, input int s);
    t_h = h; t_m = m; t_s = s;
  endtask

  // One running-clock second with the alarm not being edited.
  task automatic rtick(input string tag, input int r, input int s, input int c);
    cur_h = 6'(t_h); cur_m = 6'(t_m); cur_s = 6'(t_s);
    tick(tag, int'(m_ah), int'(m_am), r, s, c, 0);
    adv_time();
  endtask

  vec_t tbl[11];

  initial begin
    // alarm starts at 06:00 after reset
    tbl[0]  = mk( 6, 0, 0, 0,0,0,0, 0,0,0, mkexp(6,0, 0,0,0, 0)); // en=0: no ring
    tbl[1]  = mk( 6, 0, 0, 1,0,0,0, 1,0,0, mkexp(6,0, 0,0,0, 0)); // time_set blocks trig
    tbl[2]  = mk( 6, 0, 0, 0,1,0,0, 1,0,0, mkexp(6,0, 0,0,0, 1)); // alarm_set blocks trig
    tbl[3]  = mk(12, 0,30, 0,1,1,0, 0,0,0, mkexp(7,0, 0,0,0, 1));
    tbl[4]  = mk(12, 0,31, 1,1,1,0, 0,0,0, mkexp(7,0, 0,0,0, 0)); // time_set wins
    tbl[5]  = mk(12, 0,32, 0,1,0,1, 0,0,0, mkexp(7,1, 0,0,0, 1));
    tbl[6]  = mk(12, 0,33, 0,1,1,1, 0,0,0, mkexp(8,2, 0,0,0, 1)); // both fields
    tbl[7]  = mk(12, 0,34, 0,0,1,1, 0,0,0, mkexp(8,2, 0,0,0, 0)); // no edit mode
    tbl[8]  = mk( 8, 2, 0, 0,0,0,0, 1,0,0, mkexp(8,2, 1,0,0, 0)); // match at 08:02:00
    tbl[9]  = mk( 8, 2, 1, 0,0,0,0, 1,0,1, mkexp(8,2, 0,0,0, 0)); // stop
    tbl[10] = mk( 8, 2, 2, 0,0,0,0, 1,0,0, mkexp(8,2, 0,0,0, 0));

    rst = 1'b1;
    cur_h = '0; cur_m = '0; cur_s = '0;
    time_set = 0; alarm_set = 0; inc_hr = 0; inc_min = 0;
    alarm_en = 0; snooze = 0; stop = 0;
    @(posedge clk_1hz);
    #1;
    tick("reset", 6, 0, 0, 0, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      cur_h = tbl[i].h; cur_m = tbl[i].m; cur_s = tbl[i].s;
      time_set = tbl[i].ts; alarm_set = tbl[i].as;
      inc_hr = tbl[i].ih; inc_min = tbl[i].im;
      alarm_en = tbl[i].en; snooze = tbl[i].sn; stop = tbl[i].sp;
      tick($sformatf("vec%0d", i), int'(tbl[i].e.ah), int'(tbl[i].e.am),
           int'(tbl[i].e.ring), int'(tbl[i].e.snz), int'(tbl[i].e.cnt),
           int'(tbl[i].e.edit));
    end
    snooze = 0; stop = 0;
    m_ah = 6'd8; m_am = 6'd2;

    // hour and minute wrap during editing
    alarm_en = 0; time_set = 0; alarm_set = 1; inc_hr = 1; inc_min = 0;
    while (m_ah != 6'd23) begin
      m_ah = m_ah + 6'd1;
      tick("edit_hr", int'(m_ah), int'(m_am), 0, 0, 0, 1);
    end
    m_ah = 6'd0;
    tick("hr_wrap", 0, int'(m_am), 0, 0, 0, 1);
    inc_hr = 0; inc_min = 1;
    while (m_am != 6'd59) begin
      m_am = m_am + 6'd1;
      tick("edit_min", int'(m_ah), int'(m_am), 0, 0, 0, 1);
    end
    m_am = 6'd0;
    tick("min_wrap", 0, 0, 0, 0, 0, 1);
    time_set = 1; inc_hr = 1; inc_min = 1;
    tick("ts_block", 0, 0, 0, 0, 0, 0);
    time_set = 0; alarm_set = 0; inc_hr = 0; inc_min = 0;

    rst = 1; m_ah = 6'd6; m_am = 6'd0;
    tick("reset2", 6, 0, 0, 0, 0, 0);
    rst = 0;

    // uninterrupted ring: exactly 60 cycles
    alarm_en = 1;
    set_time(5, 59, 59);
    rtick("pre_match", 0, 0, 0);
    rtick("ring_rise", 1, 0, 0);
    for (int k = 2; k <= 60; k++) rtick("ring_hold", 1, 0, 0);
    rtick("auto_stop", 0, 0, 0);
    rtick("no_refire", 0, 0, 0);

    // three snoozes of exactly 300 cycles, fourth ignored
    set_time(6, 0, 0);
    rtick("snz_trig", 1, 0, 0);
    for (int k = 2; k <= 10; k++) rtick("snz_pre", 1, 0, 0);
    for (int n = 1; n <= 3; n++) begin
      snooze = 1;
      rtick("snz_enter", 0, 1, n);
      snooze = 0;
      for (int j = 1; j < 300; j++) rtick("snz_hold", 0, 1, n);
      rtick("snz_resume", 1, 0, n);
    end
    snooze = 1;
    rtick("snz_ignored", 1, 0, 3);
    snooze = 0;
    rtick("snz_ignored2", 1, 0, 3);
    stop = 1;
    rtick("stop", 0, 0, 3);
    stop = 0;
    rtick("cnt_hold", 0, 0, 3);

    // disarm during snooze
    set_time(6, 0, 0);
    rtick("trig2", 1, 0, 0);
    snooze = 1;
    rtick("snz2", 0, 1, 1);
    snooze = 0;
    rtick("snz2_hold", 0, 1, 1);
    alarm_en = 0;
    rtick("en_off", 0, 0, 1);
    alarm_en = 1;
    rtick("en_back", 0, 0, 1);

    // stop + snooze together: stop wins, count not bumped
    set_time(6, 0, 0);
    rtick("trig3", 1, 0, 0);
    snooze = 1;
    rtick("snz3", 0, 1, 1);
    snooze = 0;
    for (int j = 1; j < 300; j++) rtick("snz3_hold", 0, 1, 1);
    rtick("snz3_resume", 1, 0, 1);
    stop = 1; snooze = 1;
    rtick("stop_snz", 0, 0, 1);
    stop = 0; snooze = 0;

    // move alarm to 07:00 so reset has something to restore
    alarm_set = 1; inc_hr = 1; m_ah = 6'd7;
    tick("edit7", 7, 0, 0, 0, 1, 1);
    alarm_set = 0; inc_hr = 0;
    set_time(7, 0, 0);
    rtick("trig4", 1, 0, 0);
    snooze = 1;
    rtick("snz4", 0, 1, 1);
    snooze = 0;
    for (int j = 1; j < 300; j++) rtick("snz4_hold", 0, 1, 1);
    rtick("snz4_resume", 1, 0, 1);
    rtick("ring4", 1, 0, 1);
    rst = 1; m_ah = 6'd6; m_am = 6'd0;
    rtick("rst_mid_ring", 0, 0, 0);
    rst = 0;
    rtick("post_rst", 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
